// File: rtl/missile_scheduler_pkg.sv
// Shared playfield constants and small helpers for the invader missile scheduler.
// Invader grid geometry lives here so the renderer and the scheduler agree on it.
package missile_scheduler_pkg;

  localparam int INVADERS_H            = 11;
  localparam int INVADERS_V            = 5;
  localparam int INVADERS_OFFSET_H     = 32;
  localparam int INVADERS_OFFSET_V     = 24;
  localparam int INVADER_WIDTH_SCALED  = 24;
  localparam int INVADER_HEIGHT_SCALED = 16;
  localparam int INV_BITS              = INVADERS_H * INVADERS_V;
  localparam int NUM_SLOTS             = 3;

  typedef struct packed {
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
  } slot_t;

  function automatic slot_t slot_parked(input logic [9:0] park_y);
    slot_t s;
    s.active = 1'b0;
    s.x      = 10'd0;
    s.y      = park_y;
    return s;
  endfunction

  function automatic logic [3:0] col_next(input logic [3:0] c);
    logic [3:0] n;
    if (c >= 4'(INVADERS_H - 1)) n = 4'd0;
    else n = c + 4'd1;
    return n;
  endfunction

  // Alive-mask bit for row r (0 = top), column c
  function automatic logic [5:0] inv_index(input int r, input logic [3:0] c);
    return 6'(r * INVADERS_H) + {2'b00, c};
  endfunction

  function automatic logic col_alive(input logic [INV_BITS-1:0] inv, input logic [3:0] c);
    logic       hit;
    logic [5:0] idx;
    hit = 1'b0;
    for (int r = 0; r < INVADERS_V; r++) begin
      idx = inv_index(r, c);
      if (idx < 6'(INV_BITS)) hit = hit | inv[idx];
      else hit = hit;
    end
    return hit;
  endfunction

  // The shooter is the lowest alive invader on screen, i.e. the highest row index
  function automatic logic [2:0] shooter_row(input logic [INV_BITS-1:0] inv, input logic [3:0] c);
    logic [2:0] row;
    logic [5:0] idx;
    row = 3'd0;
    for (int r = 0; r < INVADERS_V; r++) begin
      idx = inv_index(r, c);
      if ((idx < 6'(INV_BITS)) && inv[idx]) row = 3'(r);
      else row = row;
    end
    return row;
  endfunction

endpackage

// File: rtl/missile_scheduler_lfsr8.sv
// Free-running 8-bit maximal-length LFSR (x^8 + x^6 + x^5 + x^4 + 1) used to pick
// the first column tried when searching for a shooter.
module lfsr8 (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);

  logic       fb_s;
  logic [7:0] q_d;

  // Next state; the all-zero lock-up state is steered back to the seed
  always_comb begin
    fb_s = q[7] ^ q[5] ^ q[4] ^ q[3];
    q_d  = {q[6:0], fb_s};
    if (q_d == 8'h00) q_d = 8'h01;
    else q_d = q_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 8'h01;
    else q <= q_d;
  end

endmodule

// File: rtl/missile_scheduler.sv
// Invader missile scheduler: once per frame moves the three missile slots, and when a
// shot is due searches for a shooter column and spawns a missile below it.
module missile_scheduler
  import missile_scheduler_pkg::*;
#(
  parameter int FIRE_PERIOD   = 32,
  parameter int MISSILE_SPEED = 2,
  parameter int BOTTOM_Y      = 470,
  parameter int PARK_Y        = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame,
  input  logic                game_active,
  input  logic [INV_BITS-1:0] invaders,
  input  logic [9:0]          invaders_x,
  input  logic [9:0]          invaders_y,
  input  logic [1:0]          player_collision,
  output logic [9:0]          m1_x,
  output logic [9:0]          m1_y,
  output logic [9:0]          m2_x,
  output logic [9:0]          m2_y,
  output logic [9:0]          m3_x,
  output logic [9:0]          m3_y,
  output logic [2:0]          m_active,
  output logic                busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MOVE   = 2'd1;
  localparam logic [1:0] ST_SEARCH = 2'd2;
  localparam logic [1:0] ST_SPAWN  = 2'd3;

  localparam int              CW       = $clog2(FIRE_PERIOD + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(FIRE_PERIOD);
  localparam logic [9:0]      PARK     = 10'(PARK_Y);
  localparam logic [10:0]     BOTTOM   = 11'(BOTTOM_Y);
  localparam logic [10:0]     SPEED    = 11'(MISSILE_SPEED);
  localparam logic [3:0]      LAST_TRY = 4'(INVADERS_H - 1);

  logic [1:0]    state_q, state_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    tries_q, tries_d;
  logic [2:0]    row_q, row_d;
  logic          busy_q;
  slot_t         slot_q [NUM_SLOTS];
  slot_t         slot_d [NUM_SLOTS];

  logic [7:0]    lfsr_s;
  logic [10:0]   y_next_s;
  logic          any_free_s;
  logic          spawned_s;
  logic [9:0]    spawn_x_s;
  logic [9:0]    spawn_y_s;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_s)
  );

  // Muzzle position below the latched shooter, relative to the current block origin
  always_comb begin
    spawn_x_s = invaders_x + (10'(col_q) * 10'(INVADERS_OFFSET_H)) + 10'(INVADER_WIDTH_SCALED / 2);
    spawn_y_s = invaders_y + (10'(row_q) * 10'(INVADERS_OFFSET_V)) + 10'(INVADER_HEIGHT_SCALED);
  end

  // Frame sequencing, slot updates, player-hit clearing and game freeze
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    tries_d    = tries_q;
    row_d      = row_q;
    slot_d     = slot_q;
    y_next_s   = 11'd0;
    any_free_s = 1'b0;
    spawned_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame || pend_q) begin
          state_d = ST_MOVE;
          pend_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_MOVE: begin
        pend_d = pend_q | frame;
        // 11-bit sum so a missile near the 10-bit ceiling cannot wrap back on screen
        for (int k = 0; k < NUM_SLOTS; k++) begin
          y_next_s = {1'b0, slot_q[k].y} + SPEED;
          if (!slot_q[k].active) slot_d[k] = slot_q[k];
          else if (y_next_s > BOTTOM) slot_d[k] = slot_parked(PARK);
          else slot_d[k].y = y_next_s[9:0];
          any_free_s = any_free_s | ~slot_d[k].active;
        end
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        else cnt_d = CNT_MAX;
        if ((cnt_d == CNT_MAX) && any_free_s) begin
          state_d = ST_SEARCH;
          col_d   = 4'(lfsr_s % 8'(INVADERS_H));
          tries_d = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SEARCH: begin
        pend_d = pend_q | frame;
        if (col_alive(invaders, col_q)) begin
          row_d   = shooter_row(invaders, col_q);
          state_d = ST_SPAWN;
        end else begin
          col_d   = col_next(col_q);
          tries_d = tries_q + 4'd1;
          if (tries_q >= LAST_TRY) state_d = ST_IDLE;
          else state_d = ST_SEARCH;
        end
      end

      ST_SPAWN: begin
        pend_d = pend_q | frame;
        for (int k = 0; k < NUM_SLOTS; k++) begin
          if (!slot_q[k].active && !spawned_s) begin
            slot_d[k] = '{active: 1'b1, x: spawn_x_s, y: spawn_y_s};
            spawned_s = 1'b1;
          end else begin
            spawned_s = spawned_s;
          end
        end
        if (spawned_s) cnt_d = {CW{1'b0}};
        else cnt_d = cnt_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Hits only clear slots already in flight, so they never collide with a spawn target
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if ((player_collision == 2'(k + 1)) && slot_q[k].active) slot_d[k] = slot_parked(PARK);
      else slot_d[k] = slot_d[k];
    end

    if (!game_active) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
      cnt_d   = {CW{1'b0}};
      for (int k = 0; k < NUM_SLOTS; k++) slot_d[k] = slot_parked(PARK);
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      col_q   <= 4'd0;
      tries_q <= 4'd0;
      row_q   <= 3'd0;
      busy_q  <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) slot_q[k] <= slot_parked(PARK);
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      tries_q <= tries_d;
      row_q   <= row_d;
      busy_q  <= (state_d != ST_IDLE);
      for (int k = 0; k < NUM_SLOTS; k++) slot_q[k] <= slot_d[k];
    end
  end

  assign m1_x     = slot_q[0].x;
  assign m1_y     = slot_q[0].y;
  assign m2_x     = slot_q[1].x;
  assign m2_y     = slot_q[1].y;
  assign m3_x     = slot_q[2].x;
  assign m3_y     = slot_q[2].y;
  assign m_active = {slot_q[2].active, slot_q[1].active, slot_q[0].active};
  assign busy     = busy_q;

endmodule

// File: tb/tb_missile_scheduler.sv
// Bench for missile_scheduler: a frame-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed positions and timings.
module tb_missile_scheduler;
  import missile_scheduler_pkg::*;

  localparam int FP   = 32;
  localparam int SPD  = 2;
  localparam int BOT  = 470;
  localparam int PARK = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame = 1'b0;
  logic        game_active = 1'b0;
  logic [54:0] invaders = '0;
  logic [9:0]  inv_x = 10'd0;
  logic [9:0]  inv_y = 10'd0;
  logic [1:0]  pcol = 2'd0;
  logic [9:0]  m1_x, m1_y, m2_x, m2_y, m3_x, m3_y;
  logic [2:0]  m_active;
  logic        busy;

  int errors = 0;
  int checks = 0;

  missile_scheduler dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .game_active(game_active),
    .invaders(invaders), .invaders_x(inv_x), .invaders_y(inv_y),
    .player_collision(pcol),
    .m1_x(m1_x), .m1_y(m1_y), .m2_x(m2_x), .m2_y(m2_y), .m3_x(m3_x), .m3_y(m3_y),
    .m_active(m_active), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mact[3], mx[3], my[3];
  int cnt, pend, lf, left, move_due, spawn_ok, s_col, s_row;

  function automatic int lfsr_next(input int v);
    return ((v << 1) & 255) | (((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1);
  endfunction

  function automatic bit alive(input logic [54:0] inv, input int r, input int c);
    return ((inv >> (r * 11 + c)) & 55'd1) != 55'd0;
  endfunction

  task automatic park(input int k);
    mact[k] = 0; mx[k] = 0; my[k] = PARK;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) park(k);
    cnt = 0; pend = 0; left = 0; move_due = 0; spawn_ok = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    int lf_now, found, c, placed, free_any;
    int pre[3];
    if (!rst_n) begin
      model_clear();
      lf = 1;
    end else begin
      lf_now = lf;
      lf = lfsr_next(lf);
      if (!game_active) model_clear();
      else begin
        for (int k = 0; k < 3; k++) pre[k] = mact[k];
        if (left == 0) begin
          if (frame || pend != 0) begin left = 1; move_due = 1; pend = 0; end
        end else begin
          if (frame) pend = 1;
          if (move_due != 0) begin
            move_due = 0;
            for (int k = 0; k < 3; k++)
              if (mact[k] != 0) begin
                my[k] += SPD;
                if (my[k] > BOT) park(k);
              end
            if (cnt < FP) cnt++;
            free_any = (mact[0] == 0 || mact[1] == 0 || mact[2] == 0) ? 1 : 0;
            left = 0;
            if (cnt == FP && free_any != 0) begin
              found = 0; left = 11; spawn_ok = 0;
              for (int i = 0; i < 11; i++) begin
                c = (lf_now % 11 + i) % 11;
                if (found == 0) begin
                  for (int r = 0; r < 5; r++)
                    if (alive(invaders, r, c)) begin found = 1; s_col = c; s_row = r; end
                  if (found != 0) begin left = i + 2; spawn_ok = 1; end
                end
              end
            end
          end else if (left == 1 && spawn_ok != 0) begin
            placed = 0;
            for (int k = 0; k < 3; k++)
              if (pre[k] == 0 && placed == 0) begin
                mact[k] = 1;
                mx[k] = (int'(inv_x) + s_col * INVADERS_OFFSET_H + INVADER_WIDTH_SCALED / 2) % 1024;
                my[k] = (int'(inv_y) + s_row * INVADERS_OFFSET_V + INVADER_HEIGHT_SCALED) % 1024;
                placed = 1;
              end
            cnt = 0; left = 0; spawn_ok = 0;
          end else begin
            left--;
          end
        end
        if (pcol != 2'd0 && pre[int'(pcol) - 1] != 0) park(int'(pcol) - 1);
      end
    end
  end

  // Every-cycle comparison of DUT against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_active", int'(m_active), mact[0] + 2 * mact[1] + 4 * mact[2]);
      check("busy", int'(busy), (left != 0) ? 1 : 0);
      check("m1_x", int'(m1_x), mx[0]);
      check("m1_y", int'(m1_y), my[0]);
      check("m2_x", int'(m2_x), mx[1]);
      check("m2_y", int'(m2_y), my[1]);
      check("m3_x", int'(m3_x), mx[2]);
      check("m3_y", int'(m3_y), my[2]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      frame = 1'b1;
      @(negedge clk);
      frame = 1'b0;
      repeat (19) @(negedge clk);
    end
  endtask

  initial begin
    int nb;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("rst_m_active", int'(m_active), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_m1_x", int'(m1_x), 0);
    check("rst_m1_y", int'(m1_y), 1000);
    check("rst_m3_y", int'(m3_y), 1000);
    rst_n = 1'b1;
    game_active = 1'b1;
    invaders = '1;
    inv_x = 10'd40;
    inv_y = 10'd20;
    @(negedge clk);

    // first shot only after the 32nd frame, from the bottom row
    frames(31);
    check("pre_fire_m_active", int'(m_active), 0);
    frames(1);
    check("fire1_m_active", int'(m_active), 1);
    check("fire1_m1_y", int'(m1_y), 132);

    // only column 10 alive: x fixed whatever the LFSR gives
    invaders = '0;
    invaders[54] = 1'b1;
    frames(32);
    check("col10_m_active", int'(m_active), 3);
    check("col10_m2_x", int'(m2_x), 372);
    check("col10_m2_y", int'(m2_y), 132);

    invaders = '1;
    frames(32);
    check("three_m_active", int'(m_active), 7);
    frames(31);
    // due frame with slot 2 hit during MOVE: cleared, no spawn
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    pcol = 2'd2;
    @(negedge clk);
    pcol = 2'd0;
    repeat (18) @(negedge clk);
    check("hit_m_active", int'(m_active), 5);
    check("hit_m2_y", int'(m2_y), 1000);
    frames(1);
    check("respawn_m_active", int'(m_active), 7);
    check("respawn_m2_y", int'(m2_y), 132);

    // game freeze clears everything on the next edge
    game_active = 1'b0;
    @(negedge clk);
    check("freeze_m_active", int'(m_active), 0);
    check("freeze_busy", int'(busy), 0);
    game_active = 1'b1;
    invaders = '0;
    invaders[0] = 1'b1;
    inv_y = 10'd452;
    frames(32);
    check("edge_spawn_y", int'(m1_y), 468);
    frames(1);
    check("edge_470_y", int'(m1_y), 470);
    check("edge_470_active", int'(m_active), 1);
    frames(1);
    check("edge_retire_active", int'(m_active), 0);
    check("edge_retire_y", int'(m1_y), 1000);

    // empty grid: 11-cycle search, no spawn, counter stays saturated
    game_active = 1'b0;
    @(negedge clk);
    game_active = 1'b1;
    invaders = '0;
    frames(31);
    frame = 1'b1;
    nb = 0;
    repeat (25) begin
      @(negedge clk);
      frame = 1'b0;
      if (busy) nb++;
    end
    check("empty_busy_cycles", nb, 12);
    check("empty_m_active", int'(m_active), 0);
    frame = 1'b1;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      frame = (i == 4) ? 1'b1 : 1'b0;
      if (busy) nb++;
    end
    check("pending_busy_cycles", nb, 24);

    // game_active dropped mid-search
    invaders[0] = 1'b1;
    inv_y = 10'd20;
    frames(1);
    check("pre_drop_m_active", int'(m_active), 1);
    invaders = '0;
    frames(31);
    frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_search_busy", int'(busy), 1);
    game_active = 1'b0;
    @(negedge clk);
    check("drop_m_active", int'(m_active), 0);
    check("drop_busy", int'(busy), 0);
    game_active = 1'b1;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/missile_scheduler.md
MISSILE_SCHEDULER -- requirements
Module: missile_scheduler

Interface
REQ-001 Parameter FIRE_PERIOD, default 32, frames between invader shots.
REQ-002 Parameter MISSILE_SPEED, default 2, pixels of downward motion per frame.
REQ-003 Parameter BOTTOM_Y, default 470; a missile whose y exceeds this retires.
REQ-004 Parameter PARK_Y, default 1000; y driven for an inactive slot (off-screen).
REQ-005 clk  in  1  system pixel clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 frame  in  1  one-cycle pulse at start of blanking.
REQ-008 game_active  in  1  low = freeze and clear all missiles.
REQ-009 invaders  in  55  alive mask; bit r*11+c = row r (0 top), column c.
REQ-010 invaders_x, invaders_y  in  10 each  top-left of invader block.
REQ-011 player_collision  in  2  0 = none; k = missile slot k hit player.
REQ-012 m1_x, m1_y, m2_x, m2_y, m3_x, m3_y  out  10 each  missile positions.
REQ-013 m_active  out  3  bit k-1 = slot k in flight.
REQ-014 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, MOVE, SEARCH, SPAWN.
REQ-016 IDLE -> MOVE when frame or frame_pending is set and game_active is high; frame_pending clears on entering MOVE.
REQ-017 A frame pulse in any non-IDLE state SHALL set frame_pending; at most one is held.
REQ-018 MOVE (1 cycle): each active slot y += MISSILE_SPEED; a slot whose new y > BOTTOM_Y deactivates; frame counter increments, saturating at FIRE_PERIOD.
REQ-019 MOVE -> SEARCH if counter == FIRE_PERIOD and any slot is free, else -> IDLE.
REQ-020 SEARCH SHALL test one column per cycle, starting at lfsr value mod 11 and incrementing mod 11, for at most 11 cycles.
REQ-021 A column is eligible if any of its 5 bits is set; the shooter is its highest-index (lowest) alive row.
REQ-022 SEARCH -> SPAWN on the first eligible column; -> IDLE after 11 ineligible columns, with the counter kept saturated.
REQ-023 SPAWN (1 cycle) SHALL fill the lowest-index free slot with x = invaders_x + c*INVADERS_OFFSET_H + INVADER_WIDTH_SCALED/2 and y = invaders_y + r*INVADERS_OFFSET_V + INVADER_HEIGHT_SCALED, set its active bit, zero the counter, and advance the LFSR, then go to IDLE.
REQ-024 All position arithmetic SHALL be 10-bit unsigned; MOVE SHALL compare in 11 bits so wrap-around cannot keep a missile alive.
REQ-025 player_collision = k with slot k active SHALL deactivate slot k on the next edge in any state; a report for an inactive slot SHALL be ignored.
REQ-026 A collision clear and a spawn in the same cycle SHALL both take effect; spawn only targets slots inactive before that cycle.
REQ-027 An inactive slot SHALL drive x = 0, y = PARK_Y.
REQ-028 game_active low SHALL clear all slots, counter, and frame_pending, and force IDLE within one cycle; the LFSR keeps running.
REQ-029 The LFSR SHALL be 8-bit maximal (taps 8,6,5,4), advancing every cycle, never zero.

Reset
REQ-030 On rst_n low, asynchronously: FSM = IDLE, m_active = 0, all x = 0, all y = PARK_Y, counter = 0, frame_pending = 0, busy = 0, LFSR = 8'h01.
REQ-031 Reset mid-SEARCH or mid-SPAWN SHALL abandon the shot with no slot written.

Structure
REQ-032 INVADERS_H, INVADERS_V, INVADERS_OFFSET_H/V, and INVADER_WIDTH/HEIGHT_SCALED SHALL come from the shared constants file; FSM state encodings stay local.
REQ-033 The LFSR SHALL be a sub-module named lfsr8 with ports clk, rst_n, q[7:0].

Verification
REQ-034 Reset with invaders = all ones, 32 frames -> exactly one spawn into slot 1, y = invaders_y + 4*INVADERS_OFFSET_V + INVADER_HEIGHT_SCALED.
REQ-035 Slot 1 at y = 468, MISSILE_SPEED = 2, one frame -> y = 470 still active; next frame -> inactive, y = 1000.
REQ-036 Only column 10 alive (bit 54 set), fire due -> spawn x = invaders_x + 10*INVADERS_OFFSET_H + INVADER_WIDTH_SCALED/2 regardless of LFSR start.
REQ-037 invaders = 0, fire due -> SEARCH lasts 11 cycles, no spawn, counter stays at 32.
REQ-038 All three slots active and player_collision = 2 during SPAWN-eligible frame -> slot 2 cleared; no spawn that frame; next due frame spawns into slot 2.
REQ-039 game_active dropped mid-SEARCH -> m_active = 0 and busy = 0 on the next edge.
